// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: register file with two async read ports, one sync write port,
// optional write->read bypass and a per-register busy scoreboard for RAW hazard detection.
module reg_file_scoreboard #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [AW-1:0]    readRegister1,
   input  logic [AW-1:0]    readRegister2,
   output logic [WIDTH-1:0] readData1,
   output logic [WIDTH-1:0] readData2,
   output logic             busy1,
   output logic             busy2,
   input  logic [AW-1:0]    writeRegister,
   input  logic [WIDTH-1:0] writeData,
   input  logic             regWrite,
   input  logic [AW-1:0]    reserveRegister,
   input  logic             reserve,
   output logic [AW:0]      busyCount
);
   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0] busy_q, busy_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             wr_ok, res_ok, inc, dec, byp1, byp2, res1, res2;
   assign wr_ok  = regWrite && !(ZERO_REG != 0 && writeRegister == '0);
   assign res_ok = reserve && !(ZERO_REG != 0 && reserveRegister == '0);
   assign byp1   = BYPASS != 0 && wr_ok && writeRegister == readRegister1;
   assign byp2   = BYPASS != 0 && wr_ok && writeRegister == readRegister2;
   assign res1   = res_ok && reserveRegister == readRegister1;
   assign res2   = res_ok && reserveRegister == readRegister2;
   // Register 0 is never written when ZERO_REG is set, so its storage stays at its reset zero.
   assign readData1 = reset ? '0 : byp1 ? writeData : regs_q[readRegister1];
   assign readData2 = reset ? '0 : byp2 ? writeData : regs_q[readRegister2];
   assign busy1     = !reset && busy_q[readRegister1] && !(byp1 && !res1);
   assign busy2     = !reset && busy_q[readRegister2] && !(byp2 && !res2);
   assign busyCount = cnt_q;
   assign inc = res_ok && !busy_q[reserveRegister];
   assign dec = wr_ok && busy_q[writeRegister] && !(res_ok && reserveRegister == writeRegister);
   assign cnt_d = cnt_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
   // Reserve is applied after the clear so it wins on the same register.
   always_comb begin
      busy_d = busy_q;
      if (wr_ok) busy_d[writeRegister] = 1'b0;
      if (res_ok) busy_d[reserveRegister] = 1'b1;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_ok) regs_q[writeRegister] <= writeData;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard: directed table-driven bench for reg_file_scoreboard,
// with a BYPASS=0 twin sharing the stimulus to compare forwarding behaviour.
module tb_reg_file_scoreboard;
   logic        clk = 1'b0, reset = 1'b1;
   logic [4:0]  ra1 = '0, ra2 = '0, wa = '0, rr = '0;
   logic [31:0] wd = '0;
   logic        we = 1'b0, rv = 1'b0;
   logic [31:0] d1, d2, n1, n2;
   logic        b1, b2, nb1, nb2;
   logic [5:0]  cnt, ncnt;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   reg_file_scoreboard dut (
      .clk(clk), .reset(reset), .readRegister1(ra1), .readRegister2(ra2),
      .readData1(d1), .readData2(d2), .busy1(b1), .busy2(b2),
      .writeRegister(wa), .writeData(wd), .regWrite(we),
      .reserveRegister(rr), .reserve(rv), .busyCount(cnt));

   reg_file_scoreboard #(.BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .readRegister1(ra1), .readRegister2(ra2),
      .readData1(n1), .readData2(n2), .busy1(nb1), .busy2(nb2),
      .writeRegister(wa), .writeData(wd), .regWrite(we),
      .reserveRegister(rr), .reserve(rv), .busyCount(ncnt));

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        rv;
      logic [4:0]  rr;
      logic [4:0]  a1, a2;
      logic [31:0] e1, e2;
      logic        eb1, eb2;
      logic [5:0]  ecnt;
   } vec_t;
   vec_t v [16];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic r, input logic [4:0] rs, input logic [4:0] x1, input logic [4:0] x2);
      we = w; wa = a; wd = d; rv = r; rr = rs; ra1 = x1; ra2 = x2;
   endtask

   initial begin
      // we wa wd  rv rr  a1 a2  e1 e2  eb1 eb2 ecnt  (checked before the committing edge)
      v[0]  = '{0, 0, 0,            0, 0, 2, 3, 0,            0,   0, 0, 0};
      v[1]  = '{1, 2, 42,           0, 0, 2, 2, 42,           42,  0, 0, 0};
      v[2]  = '{1, 2, 15,           0, 0, 2, 2, 15,           15,  0, 0, 0};
      v[3]  = '{0, 2, 17,           0, 0, 2, 2, 15,           15,  0, 0, 0};
      v[4]  = '{1, 3, 19,           0, 0, 2, 3, 15,           19,  0, 0, 0};
      v[5]  = '{0, 0, 0,            0, 0, 2, 3, 15,           19,  0, 0, 0};
      v[6]  = '{1, 0, 15,           0, 0, 0, 0, 0,            0,   0, 0, 0};
      v[7]  = '{0, 0, 0,            1, 0, 0, 2, 0,            15,  0, 0, 0};
      v[8]  = '{0, 0, 0,            0, 0, 0, 0, 0,            0,   0, 0, 0};
      v[9]  = '{0, 0, 0,            1, 4, 4, 7, 0,            0,   0, 0, 0};
      v[10] = '{0, 0, 0,            1, 7, 4, 7, 0,            0,   1, 0, 1};
      v[11] = '{0, 0, 0,            1, 4, 4, 7, 0,            0,   1, 1, 2};
      v[12] = '{1, 4, 100,          0, 0, 4, 7, 100,          0,   0, 1, 2};
      v[13] = '{1, 7, 77,           1, 9, 7, 9, 77,           0,   0, 0, 1};
      v[14] = '{1, 9, 5,            1, 9, 9, 7, 5,            77,  1, 0, 1};
      v[15] = '{0, 0, 0,            0, 0, 9, 4, 5,            100, 1, 0, 1};

      // Writes and reservations while reset is held must be ignored and reads forced to 0.
      drive(1, 3, 32'hFF, 1, 3, 3, 3);
      #2;
      chk("rst_rd1", d1, 0);
      chk("rst_busy1", b1, 0);
      @(posedge clk); #1;
      chk("rst_cnt", cnt, 0);
      drive(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < 32; a++) begin
         ra1 = a[4:0]; ra2 = 5'(31 - a);
         #1;
         chk($sformatf("init_rd1[%0d]", a), d1, 0);
         chk($sformatf("init_rd2[%0d]", a), d2, 0);
         if (b1 || b2) chk($sformatf("init_busy[%0d]", a), {b1, b2}, 0);
      end
      chk("init_cnt", cnt, 0);

      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         drive(v[i].we, v[i].wa, v[i].wd, v[i].rv, v[i].rr, v[i].a1, v[i].a2);
         @(negedge clk);
         chk($sformatf("v%0d_rd1", i), d1, v[i].e1);
         chk($sformatf("v%0d_rd2", i), d2, v[i].e2);
         chk($sformatf("v%0d_busy1", i), b1, v[i].eb1);
         chk($sformatf("v%0d_busy2", i), b2, v[i].eb2);
         chk($sformatf("v%0d_cnt", i), cnt, v[i].ecnt);
      end

      // Bypass vs no bypass: give r5 an old value, then overwrite it.
      @(posedge clk); #1;
      drive(1, 5, 32'h1234, 0, 0, 5, 5);
      @(posedge clk); #1;
      drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
      @(negedge clk);
      chk("byp_rd1", d1, 32'hDEADBEEF);
      chk("byp_busy1", b1, 0);
      chk("nobyp_rd1", n1, 32'h1234);
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 5, 9);
      @(negedge clk);
      chk("nobyp_rd1_after", n1, 32'hDEADBEEF);
      chk("nobyp_busy2", nb2, 1);
      chk("cnt_after_nonbusy_write", cnt, 1);

      // Reserve r1..r6 then assert reset mid-cycle.
      for (int r = 1; r <= 6; r++) begin
         @(posedge clk); #1;
         drive(0, 0, 0, 1, r[4:0], 2, 6);
      end
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 0, 2, 6);
      @(negedge clk);
      chk("pre_rst_cnt", cnt, 7);
      chk("pre_rst_busy2", b2, 1);
      chk("pre_rst_rd1", d1, 15);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_cnt", cnt, 0);
      chk("mid_rst_nb_cnt", ncnt, 0);
      chk("mid_rst_busy2", b2, 0);
      chk("mid_rst_rd1", d1, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst_rd1", d1, 0);
      chk("post_rst_busy2", b2, 0);
      chk("post_rst_cnt", cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
